// File: rtl/riscv_insn_memory.sv
// riscv_insn_memory: instruction-fetch responder with valid/ready request and
// response channels, optional wait states and an independent load port.
// Optional feature macro: RISCV_INSN_MEM_MISALIGN_TRAP_EN (fault on addr[1:0]!=0).
module riscv_insn_memory #(
    parameter int XLEN        = 32,
    parameter int DEPTH       = 256,
    parameter int WAIT_CYCLES = 0
) (
    input  logic                     clock,
    input  logic                     reset,
    input  logic                     req_valid,
    output logic                     req_ready,
    input  logic [XLEN-1:0]          insn_addr,
    output logic                     resp_valid,
    input  logic                     resp_ready,
    output logic [XLEN-1:0]          insn_data,
    output logic                     resp_error,
    input  logic                     load_enable,
    input  logic [$clog2(DEPTH)-1:0] load_addr,
    input  logic [XLEN-1:0]          load_data
);

    localparam int AW = $clog2(DEPTH);

`ifdef RISCV_INSN_MEM_MISALIGN_TRAP_EN
    localparam bit MISALIGN_TRAP = 1'b1;
`else
    localparam bit MISALIGN_TRAP = 1'b0;
`endif

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_WAIT = 2'd1,
        S_RESP = 2'd2
    } state_t;

    state_t           r_state;
    logic [3:0]       r_cnt;
    logic [XLEN-1:0]  r_addr;
    logic             r_resp_valid;
    logic [XLEN-1:0]  r_insn_data;
    logic             r_resp_error;
    logic [XLEN-1:0]  r_mem [DEPTH];

    logic             w_accept;
    logic [XLEN-1:0]  w_rd_addr;
    logic [AW-1:0]    w_rd_idx;
    logic             w_rd_oor;
    logic             w_rd_mis;
    logic             w_rd_err;
    logic [XLEN-1:0]  w_rd_data;

    // Ready depends only on state and resp_ready so it never loops through req_valid
    assign req_ready = !reset &&
                       ((r_state == S_IDLE) || ((r_state == S_RESP) && resp_ready));
    assign w_accept  = req_valid && req_ready;

    // The array is read on the cycle that enters RESP: the live address when
    // entering directly from acceptance, the captured one when leaving WAIT.
    assign w_rd_addr = (r_state == S_WAIT) ? r_addr : insn_addr;
    assign w_rd_idx  = w_rd_addr[AW+1:2];
    assign w_rd_oor  = |(w_rd_addr >> (AW + 2));
    assign w_rd_mis  = MISALIGN_TRAP && (|w_rd_addr[1:0]);
    assign w_rd_err  = w_rd_oor || w_rd_mis;
    assign w_rd_data = w_rd_err ? '0 : r_mem[w_rd_idx];

    // Load port: never stalls; a same-edge read sees the old word
    always_ff @(posedge clock) begin
        if (load_enable) begin
            r_mem[load_addr] <= load_data;
        end
    end

    // Fetch FSM with registered response outputs
    always_ff @(posedge clock) begin
        if (reset) begin
            r_state      <= S_IDLE;
            r_cnt        <= '0;
            r_addr       <= '0;
            r_resp_valid <= 1'b0;
            r_insn_data  <= '0;
            r_resp_error <= 1'b0;
        end else if (w_accept) begin
            // Acceptance from IDLE or on the handshake cycle of RESP
            r_addr <= insn_addr;
            if (WAIT_CYCLES == 0) begin
                r_state      <= S_RESP;
                r_resp_valid <= 1'b1;
                r_insn_data  <= w_rd_data;
                r_resp_error <= w_rd_err;
            end else begin
                r_state      <= S_WAIT;
                r_cnt        <= 4'(WAIT_CYCLES);
                r_resp_valid <= 1'b0;
            end
        end else if (r_state == S_WAIT) begin
            if (r_cnt == 4'd1) begin
                r_state      <= S_RESP;
                r_cnt        <= '0;
                r_resp_valid <= 1'b1;
                r_insn_data  <= w_rd_data;
                r_resp_error <= w_rd_err;
            end else begin
                r_cnt <= r_cnt - 4'd1;
            end
        end else if ((r_state == S_RESP) && resp_ready) begin
            r_state      <= S_IDLE;
            r_resp_valid <= 1'b0;
        end
    end

    assign resp_valid = r_resp_valid;
    assign insn_data  = r_insn_data;
    assign resp_error = r_resp_error;

endmodule

// File: tb/tb_riscv_insn_memory.sv
// Scoreboard bench for riscv_insn_memory: one instance with no wait states,
// one with three; expected responses are queued at acceptance and popped by
// per-instance monitors on each response handshake.
module tb_riscv_insn_memory;

    typedef struct {
        logic [31:0] d;
        logic        e;
        int          cyc;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst0, rst3;
    logic        v0, v3, rr0, rr3, rv0, rv3, rdy0, rdy3, er0, er3;
    logic [31:0] a0, a3, d0, d3;
    logic        le;
    logic [7:0]  la;
    logic [31:0] ld;

    int   checks   = 0;
    int   failures = 0;
    int   cyc      = 0;
    exp_t q0[$];
    exp_t q3[$];
    bit   seen0 = 0, seen3 = 0;
    int   first0, first3;
    exp_t e0, e3;
    logic [31:0] words [4];

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    riscv_insn_memory #(.XLEN(32), .DEPTH(256), .WAIT_CYCLES(0)) dut0 (
        .clock(clk), .reset(rst0), .req_valid(v0), .req_ready(rr0), .insn_addr(a0),
        .resp_valid(rv0), .resp_ready(rdy0), .insn_data(d0), .resp_error(er0),
        .load_enable(le), .load_addr(la), .load_data(ld));

    riscv_insn_memory #(.XLEN(32), .DEPTH(256), .WAIT_CYCLES(3)) dut3 (
        .clock(clk), .reset(rst3), .req_valid(v3), .req_ready(rr3), .insn_addr(a3),
        .resp_valid(rv3), .resp_ready(rdy3), .insn_data(d3), .resp_error(er3),
        .load_enable(le), .load_addr(la), .load_data(ld));

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Issue one request and wait (bounded) for acceptance; queue the expectation
    task automatic req(input int sel, input logic [31:0] addr, input logic [31:0] ed,
                       input logic ee, input bit push);
        exp_t x;
        bit   ok = 0;
        if (sel == 0) begin v0 = 1'b1; a0 = addr; end
        else begin v3 = 1'b1; a3 = addr; end
        for (int i = 0; i < 50 && !ok; i++) begin
            @(negedge clk);
            if ((sel == 0) ? rr0 : rr3) ok = 1;
        end
        if (!ok) begin
            checks++;
            failures++;
            $display("FAIL req_accept_timeout: dut%0d addr %h never accepted", sel, addr);
        end else if (push) begin
            x.d   = ed;
            x.e   = ee;
            x.cyc = cyc + 1 + ((sel == 0) ? 0 : 3);
            if (sel == 0) q0.push_back(x);
            else q3.push_back(x);
        end
        @(posedge clk); #1;
        if (sel == 0) v0 = 1'b0;
        else v3 = 1'b0;
    endtask

    // Monitor for the zero-wait instance
    always @(negedge clk) begin
        if (!rst0 && rv0) begin
            if (!seen0) begin seen0 = 1; first0 = cyc; end
            if (rdy0) begin
                if (q0.size() == 0) begin
                    checks++;
                    failures++;
                    $display("FAIL dut0_unexpected_resp: data %h err %b", d0, er0);
                end else begin
                    e0 = q0.pop_front();
                    chk("dut0_data", d0, e0.d);
                    chk("dut0_err", {31'd0, er0}, {31'd0, e0.e});
                    chk("dut0_latency_cycle", first0, e0.cyc);
                end
                seen0 = 0;
            end
        end
    end

    // Monitor for the three-wait instance
    always @(negedge clk) begin
        if (!rst3 && rv3) begin
            if (!seen3) begin seen3 = 1; first3 = cyc; end
            if (rdy3) begin
                if (q3.size() == 0) begin
                    checks++;
                    failures++;
                    $display("FAIL dut3_unexpected_resp: data %h err %b", d3, er3);
                end else begin
                    e3 = q3.pop_front();
                    chk("dut3_data", d3, e3.d);
                    chk("dut3_err", {31'd0, er3}, {31'd0, e3.e});
                    chk("dut3_latency_cycle", first3, e3.cyc);
                end
                seen3 = 0;
            end
        end
    end

    initial begin
        int bad;
        words[0] = 32'h00000013;
        words[1] = 32'h00100093;
        words[2] = 32'h00200113;
        words[3] = 32'h00300193;
        rst0 = 1; rst3 = 1; v0 = 0; v3 = 0; a0 = '0; a3 = '0;
        rdy0 = 1; rdy3 = 1; le = 0; la = '0; ld = '0;

        // Reset state
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("req_ready_in_reset", {31'd0, rr0}, 32'd0);
        @(posedge clk); #1;
        rst0 = 0; rst3 = 0;
        @(negedge clk);
        chk("req_ready_after_reset", {31'd0, rr0}, 32'd1);
        chk("resp_valid_after_reset", {31'd0, rv0}, 32'd0);
        chk("insn_data_after_reset", d0, 32'd0);
        chk("resp_error_after_reset", {31'd0, er0}, 32'd0);
        @(posedge clk); #1;

        // Preload both instances
        le = 1;
        for (int i = 0; i < 4; i++) begin
            la = 8'(i); ld = words[i];
            @(posedge clk); #1;
        end
        le = 0;

        // Back-to-back fetches, one response per cycle
        for (int i = 0; i < 4; i++) req(0, 32'(i * 4), words[i], 1'b0, 1'b1);
        repeat (2) @(posedge clk); #1;

        // Backpressure: response held, queued request waits
        rdy0 = 0;
        req(0, 32'h4, words[1], 1'b0, 1'b1);
        v0 = 1; a0 = 32'h8;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            chk("bp_resp_valid", {31'd0, rv0}, 32'd1);
            chk("bp_data_stable", d0, 32'h00100093);
            chk("bp_req_ready_low", {31'd0, rr0}, 32'd0);
            @(posedge clk); #1;
        end
        rdy0 = 1;
        req(0, 32'h8, words[2], 1'b0, 1'b1);
        repeat (2) @(posedge clk); #1;

        // Out of range and misaligned
        req(0, 32'h400, 32'h0, 1'b1, 1'b1);
`ifdef RISCV_INSN_MEM_MISALIGN_TRAP_EN
        req(0, 32'h2, 32'h0, 1'b1, 1'b1);
`else
        req(0, 32'h2, 32'h00000013, 1'b0, 1'b1);
`endif
        repeat (2) @(posedge clk); #1;

        // Wait states: latency 1+3
        req(3, 32'hC, words[3], 1'b0, 1'b1);
        req(3, 32'h0, words[0], 1'b0, 1'b1);
        repeat (6) @(posedge clk); #1;

        // Reset during WAIT discards the pending response
        req(3, 32'h4, 32'h0, 1'b0, 1'b0);
        rst3 = 1;
        for (int i = 0; i < 2; i++) begin
            @(negedge clk);
            chk("req_ready_low_in_reset", {31'd0, rr3}, 32'd0);
            @(posedge clk); #1;
        end
        rst3 = 0;
        @(negedge clk);
        chk("rst_mid_req_ready", {31'd0, rr3}, 32'd1);
        chk("rst_mid_insn_data", d3, 32'd0);
        bad = 0;
        for (int i = 0; i < 6; i++) begin
            if (rv3) bad++;
            @(negedge clk);
        end
        chk("rst_mid_no_spurious_valid", 32'(bad), 32'd0);
        @(posedge clk); #1;

        // Same-cycle load and read: read-before-write, then new value
        le = 1; la = 8'd1; ld = 32'hDEADBEEF;
        req(0, 32'h4, 32'h00100093, 1'b0, 1'b1);
        le = 0;
        req(0, 32'h4, 32'hDEADBEEF, 1'b0, 1'b1);
        repeat (4) @(posedge clk); #1;

        chk("q0_drained", 32'(q0.size()), 32'd0);
        chk("q3_drained", 32'(q3.size()), 32'd0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
